spi_cardresp: RTL and testbench

SPI_CARDRESP -- requirements
Module: spi_cardresp

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_crc7.sv | 24 ++
 rtl/spi_cardresp.sv | 197 +++++++++++++++++++
 tb/tb_spi_cardresp.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared command indices, R1 bit positions, FSM states and CRC7 step for spi_cardresp
package spi_pkg;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD16 = 6'd16;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;

    localparam int R1_IDLE    = 0;
    localparam int R1_ILLEGAL = 2;
    localparam int R1_CRC     = 3;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_RECV,
        ST_CHECK,
        ST_NCR_WAIT,
        ST_SEND_R1
    } state_t;

    // One serial step of CRC7, polynomial x^7 + x^3 + 1, data MSB first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

endpackage

// File: rtl/spi_crc7.sv
// rtl/spi_crc7.sv - serial CRC7 accumulator with clear and enable (used when SPI_CARDRESP_CRC_EN is defined)
module spi_crc7
    import spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    // clr together with en folds the first bit into a fresh CRC.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= 7'd0;
        end else if (clr) begin
            crc <= en ? crc7_step(7'd0, din) : 7'd0;
        end else if (en) begin
            crc <= crc7_step(crc, din);
        end
    end

endmodule

// File: rtl/spi_cardresp.sv
// rtl/spi_cardresp.sv - SPI-mode SD card command receiver and R1 responder; SPI_CARDRESP_CRC_EN enables CRC7 checking
module spi_cardresp
    import spi_pkg::*;
#(
    parameter int NCR            = 1,
    parameter int ACMD41_RETRIES = 2
) (
    input  logic        spi_clk_i,
    input  logic        spi_rst_i,
    input  logic        SCK_SPI,
    input  logic        SS_SPI,
    input  logic        MOSI_SPI,
    output logic        MISO_SPI,
    output logic [47:0] spi_cmd_o,
    output logic        spi_cmdvalid_o,
    output logic [7:0]  spi_r1_o,
    output logic        spi_idle_o
);

    localparam logic [5:0] NCR_LAST  = 6'(NCR * 8 - 1);
    localparam logic [3:0] RETRY_MAX = 4'(ACMD41_RETRIES);

    logic [1:0] sck_sy, ss_sy, mosi_sy;
    logic       sck_d;
    logic       sck, ss_n, mosi, rise, fall;

    state_t      state, state_n;
    logic [47:0] frame;
    logic [5:0]  cnt;
    logic [7:0]  tx;
    logic        app;
    logic [3:0]  acnt;
    logic        frame_ok, crc_ok;
    logic        idle_n, app_n;
    logic [3:0]  acnt_n;
    logic [7:0]  r1_n;

    always_ff @(posedge spi_clk_i) begin
        if (spi_rst_i) begin
            sck_sy  <= 2'b00;
            ss_sy   <= 2'b11;
            mosi_sy <= 2'b11;
            sck_d   <= 1'b0;
        end else begin
            sck_sy  <= {sck_sy[0], SCK_SPI};
            ss_sy   <= {ss_sy[0], SS_SPI};
            mosi_sy <= {mosi_sy[0], MOSI_SPI};
            sck_d   <= sck_sy[1];
        end
    end

    assign sck  = sck_sy[1];
    assign ss_n = ss_sy[1];
    assign mosi = mosi_sy[1];
    assign rise = sck & ~sck_d;
    assign fall = ~sck & sck_d;

    assign frame_ok = frame[46] & frame[0];

`ifdef SPI_CARDRESP_CRC_EN
    logic [6:0] crc;
    logic       crc_clr, crc_en;

    // CRC covers bits 47..8: the start bit in HUNT, then RECV bits down to index 8.
    assign crc_clr = (state == ST_HUNT);
    assign crc_en  = rise & (((state == ST_HUNT) & ~mosi) | ((state == ST_RECV) & (cnt >= 6'd8)));

    spi_crc7 u_crc7 (
        .clk (spi_clk_i),
        .rst (spi_rst_i),
        .clr (crc_clr),
        .en  (crc_en),
        .din (mosi),
        .crc (crc)
    );

    assign crc_ok = (crc == frame[7:1]);
`else
    assign crc_ok = 1'b1;
`endif

    always_comb begin
        idle_n = spi_idle_o;
        app_n  = app;
        acnt_n = acnt;
        r1_n   = {7'b0, spi_idle_o};
        if (!crc_ok) begin
            r1_n[R1_CRC] = 1'b1;
        end else begin
            app_n = 1'b0;
            case (frame[45:40])
                CMD0: begin
                    idle_n = 1'b1;
                    acnt_n = 4'd0;
                end
                CMD8, CMD16, CMD17: ;
                CMD55: app_n = 1'b1;
                CMD41: begin
                    if (app) begin
                        if (acnt != 4'hF) acnt_n = acnt + 4'd1;
                        if (acnt_n >= RETRY_MAX) idle_n = 1'b0;
                    end else begin
                        r1_n[R1_ILLEGAL] = 1'b1;
                    end
                end
                default: r1_n[R1_ILLEGAL] = 1'b1;
            endcase
            r1_n[R1_IDLE] = idle_n;
        end
    end

    always_ff @(posedge spi_clk_i) begin
        if (spi_rst_i) state <= ST_HUNT;
        else           state <= state_n;
    end

    // A deasserted chip select overrides any edge seen in the same cycle.
    always_comb begin
        state_n = state;
        if (ss_n) begin
            state_n = ST_HUNT;
        end else begin
            case (state)
                ST_HUNT:     if (rise && !mosi) state_n = ST_RECV;
                ST_RECV:     if (rise && cnt == 6'd0) state_n = ST_CHECK;
                ST_CHECK:    state_n = frame_ok ? ST_NCR_WAIT : ST_HUNT;
                ST_NCR_WAIT: if (fall && cnt == NCR_LAST) state_n = ST_SEND_R1;
                ST_SEND_R1:  if (fall && cnt == 6'd7) state_n = ST_HUNT;
                default:     state_n = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge spi_clk_i) begin
        if (spi_rst_i) begin
            frame          <= 48'd0;
            cnt            <= 6'd0;
            tx             <= 8'hFF;
            MISO_SPI       <= 1'b1;
            spi_cmd_o      <= 48'd0;
            spi_cmdvalid_o <= 1'b0;
            spi_r1_o       <= 8'hFF;
            spi_idle_o     <= 1'b1;
            app            <= 1'b0;
            acnt           <= 4'd0;
        end else begin
            spi_cmdvalid_o <= 1'b0;
            if (ss_n) begin
                MISO_SPI <= 1'b1;
            end else begin
                case (state)
                    ST_HUNT: begin
                        // R1 bit 0 stays on the line until the next falling edge.
                        if (fall) MISO_SPI <= 1'b1;
                        if (rise && !mosi) begin
                            frame <= 48'd0;
                            cnt   <= 6'd46;
                        end
                    end
                    ST_RECV: begin
                        if (rise) begin
                            frame <= {frame[46:0], mosi};
                            cnt   <= cnt - 6'd1;
                        end
                    end
                    ST_CHECK: begin
                        cnt <= 6'd0;
                        if (frame_ok) begin
                            spi_cmd_o      <= frame;
                            spi_cmdvalid_o <= 1'b1;
                            spi_r1_o       <= r1_n;
                            tx             <= r1_n;
                            spi_idle_o     <= idle_n;
                            app            <= app_n;
                            acnt           <= acnt_n;
                        end
                    end
                    ST_NCR_WAIT: begin
                        if (fall) begin
                            MISO_SPI <= 1'b1;
                            cnt      <= (cnt == NCR_LAST) ? 6'd0 : cnt + 6'd1;
                        end
                    end
                    ST_SEND_R1: begin
                        if (fall) begin
                            MISO_SPI <= tx[7];
                            tx       <= {tx[6:0], 1'b1};
                            cnt      <= cnt + 6'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cardresp.sv
// tb/tb_spi_cardresp.sv - directed self-checking bench for spi_cardresp (SPI_CARDRESP_CRC_EN aware)
module tb_spi_cardresp;

    localparam int HALF = 6;
`ifdef SPI_CARDRESP_CRC_EN
    localparam logic CRC_ON = 1'b1;
`else
    localparam logic CRC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    logic        ss = 1'b1;
    logic        mosi = 1'b1;
    logic        miso;
    logic [47:0] cmd;
    logic        cmdvalid;
    logic [7:0]  r1;
    logic        idle;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    spi_cardresp #(.NCR(1), .ACMD41_RETRIES(2)) dut (
        .spi_clk_i      (clk),
        .spi_rst_i      (rst),
        .SCK_SPI        (sck),
        .SS_SPI         (ss),
        .MOSI_SPI       (mosi),
        .MISO_SPI       (miso),
        .spi_cmd_o      (cmd),
        .spi_cmdvalid_o (cmdvalid),
        .spi_r1_o       (r1),
        .spi_idle_o     (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cmdvalid) pulses <= pulses + 1;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 0: host sets MOSI while SCK low, samples MISO just before the rise.
    task automatic xbit(input logic m, output logic s);
        mosi = m;
        wait_clks(HALF);
        s = miso;
        sck = 1'b1;
        wait_clks(HALF);
        sck = 1'b0;
    endtask

    task automatic xbyte(input logic [7:0] t, output logic [7:0] r);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            xbit(t[i], s);
            r[i] = s;
        end
    endtask

    task automatic send_cmd(input logic [47:0] f, output logic [7:0] b1, output logic [7:0] b2);
        logic [7:0] d;
        ss = 1'b0;
        wait_clks(4);
        for (int i = 5; i >= 0; i--) xbyte(f[i*8 +: 8], d);
        xbyte(8'hFF, b1);
        xbyte(8'hFF, b2);
        wait_clks(HALF);
        ss = 1'b1;
        mosi = 1'b1;
        wait_clks(8);
    endtask

    logic [7:0]  b1, b2;
    logic        s, all_one;
    int          p0;

    initial begin
        wait_clks(3);
        rst = 1'b0;
        wait_clks(2);
        check("rst_miso", 48'(miso), 48'd1);
        check("rst_cmd", cmd, 48'd0);
        check("rst_valid", 48'(cmdvalid), 48'd0);
        check("rst_r1", 48'(r1), 48'hFF);
        check("rst_idle", 48'(idle), 48'd1);

        send_cmd(48'h400000000095, b1, b2);
        check("cmd0_ncr", 48'(b1), 48'hFF);
        check("cmd0_r1", 48'(b2), 48'h01);
        check("cmd0_r1o", 48'(r1), 48'h01);
        check("cmd0_idle", 48'(idle), 48'd1);
        check("cmd0_cmdo", cmd, 48'h400000000095);
        check("cmd0_pulse", 48'(pulses), 48'd1);

        send_cmd(48'h450000000001, b1, b2);
        check("cmd5_r1", 48'(b2), CRC_ON ? 48'h09 : 48'h05);
        check("cmd5_pulse", 48'(pulses), 48'd2);

        send_cmd(48'h694000000077, b1, b2);
        check("cmd41_noapp_r1", 48'(b2), 48'h05);
        check("cmd41_noapp_idle", 48'(idle), 48'd1);

        p0 = pulses;
        all_one = 1'b1;
        ss = 1'b0;
        wait_clks(4);
        for (int i = 47; i >= 28; i--) begin
            xbit(1'(48'h400000000095 >> i), s);
            all_one &= s;
        end
        ss = 1'b1;
        mosi = 1'b1;
        wait_clks(8);
        check("abort_pulse", 48'(pulses), 48'(p0));
        check("abort_miso", 48'(all_one & miso), 48'd1);
        send_cmd(48'h400000000095, b1, b2);
        check("after_abort_r1", 48'(b2), 48'h01);
        check("after_abort_pulse", 48'(pulses), 48'(p0 + 1));

        p0 = pulses;
        send_cmd(48'h400000000094, b1, b2);
        check("bad_stop_miso", 48'({b1, b2}), 48'hFFFF);
        check("bad_stop_pulse", 48'(pulses), 48'(p0));

        send_cmd(48'h400000000001, b1, b2);
        check("badcrc_r1", 48'(b2), CRC_ON ? 48'h09 : 48'h01);
        check("badcrc_idle", 48'(idle), 48'd1);

        send_cmd(48'h770000000065, b1, b2);
        check("cmd55a_r1", 48'(b2), 48'h01);
        send_cmd(48'h694000000077, b1, b2);
        check("acmd41a_r1", 48'(b2), 48'h01);
        check("acmd41a_idle", 48'(idle), 48'd1);
        send_cmd(48'h770000000065, b1, b2);
        check("cmd55b_r1", 48'(b2), 48'h01);
        send_cmd(48'h694000000077, b1, b2);
        check("acmd41b_r1", 48'(b2), 48'h00);
        check("acmd41b_idle", 48'(idle), 48'd0);
        check("acmd41b_r1o", 48'(r1), 48'h00);

        send_cmd(48'h48000001AA87, b1, b2);
        check("cmd8_r1", 48'(b2), 48'h00);
        check("cmd8_cmdo", cmd, 48'h48000001AA87);

        send_cmd(48'h400000000095, b1, b2);
        check("cmd0_again_r1", 48'(b2), 48'h01);
        check("cmd0_again_idle", 48'(idle), 48'd1);

        p0 = pulses;
        ss = 1'b0;
        wait_clks(4);
        for (int i = 47; i >= 18; i--) xbit(1'(48'h400000000095 >> i), s);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        for (int i = 17; i >= 0; i--) xbit(1'(48'h400000000095 >> i), s);
        for (int i = 0; i < 16; i++) xbit(1'b1, s);
        ss = 1'b1;
        mosi = 1'b1;
        wait_clks(8);
        check("midrst_pulse", 48'(pulses), 48'(p0));
        check("midrst_cmdo", cmd, 48'd0);
        check("midrst_r1o", 48'(r1), 48'hFF);
        check("midrst_miso", 48'(miso), 48'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
